// File: rtl/onchip_dpram_avl_if.sv
// Avalon-MM slave bundle for one port of onchip_dpram_avl.
// The master modport is the bus-master side; the slave modport is the RAM side.
interface onchip_dpram_avl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
);
   logic                  chipselect;
   logic                  read;
   logic                  write;
   logic [ADDR_W-1:0]     address;
   logic [DATA_W/8-1:0]   byteenable;
   logic [DATA_W-1:0]     writedata;
   logic [DATA_W-1:0]     readdata;
   logic                  readdatavalid;
   logic                  waitrequest;

   modport master (
      output chipselect, read, write, address, byteenable, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  chipselect, read, write, address, byteenable, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/onchip_dpram_avl.sv
// True-dual-port on-chip RAM with two Avalon-MM slaves, a clear-after-reset
// sequencer and s1-priority write-collision arbitration.
module onchip_dpram_avl #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 12,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  reset_req,
   input  logic                  clken,
   onchip_dpram_avl_if.slave     s1,
   onchip_dpram_avl_if.slave     s2,
   output logic                  clear_done,
   output logic [15:0]           collision_cnt
);
   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   clr_q;
   logic                done_q;
   logic                wait_q;
   logic [15:0]         coll_q, coll_d;

   logic                en, run, clr_we;
   logic                acc1, acc2, wr1, wr2, wr2_ok, coll;
   logic [1:0]          rd_acc;
   logic [ADDR_W-1:0]   rd_addr [2];

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   rdat_p1_q [2];
   logic [DATA_W-1:0]   rdat_p2_q [2];
   logic [1:0]          vld_p1_q, vld_p2_q;

   assign en     = clken & ~reset_req;
   assign run    = (state_q == ST_RUN);
   assign clr_we = (state_q == ST_CLEAR) & en;

   assign acc1   = run & en & s1.chipselect & (s1.read | s1.write);
   assign acc2   = run & en & s2.chipselect & (s2.read | s2.write);
   assign wr1    = acc1 & s1.write;
   assign wr2    = acc2 & s2.write;
   // Same-address double write: s1 commits, s2 is accepted but discarded.
   assign coll   = wr1 & wr2 & (s1.address == s2.address);
   assign wr2_ok = wr2 & ~coll;

   assign rd_acc     = {acc2 & s2.read & ~s2.write, acc1 & s1.read & ~s1.write};
   assign rd_addr[0] = s1.address;
   assign rd_addr[1] = s2.address;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         clr_q   <= '0;
         done_q  <= (CLEAR_ON_RESET == 0);
         wait_q  <= (CLEAR_ON_RESET != 0);
      end else if (clr_we) begin
         clr_q <= clr_q + ADDR_W'(1);
         if (&clr_q) begin
            state_q <= ST_RUN;
            done_q  <= 1'b1;
            wait_q  <= 1'b0;
         end
      end
   end

   // s1 lanes are assigned last so they win over s2 on a shared word.
   always_ff @(posedge clk) begin
      if (clr_we)
         mem_q[clr_q] <= '0;
      for (int b = 0; b < NB; b++) begin
         if (wr2_ok && s2.byteenable[b])
            mem_q[s2.address][8*b +: 8] <= s2.writedata[8*b +: 8];
         if (wr1 && s1.byteenable[b])
            mem_q[s1.address][8*b +: 8] <= s1.writedata[8*b +: 8];
      end
   end

   // ---- stage p1: RAM read; stage p2: optional output register ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1_q <= '0;
         vld_p2_q <= '0;
         for (int p = 0; p < 2; p++) begin
            rdat_p1_q[p] <= '0;
            rdat_p2_q[p] <= '0;
         end
      end else if (en) begin
         vld_p1_q <= rd_acc;
         vld_p2_q <= vld_p1_q;
         for (int p = 0; p < 2; p++) begin
            if (rd_acc[p])
               rdat_p1_q[p] <= mem_q[rd_addr[p]];
            if (vld_p1_q[p])
               rdat_p2_q[p] <= rdat_p1_q[p];
         end
      end
   end

   always_comb begin
      coll_d = coll_q;
      if (coll && coll_q != 16'hFFFF)
         coll_d = coll_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) coll_q <= '0;
      else       coll_q <= coll_d;
   end

   // Valid is masked while stalled so a frozen pulse is seen in exactly one en-cycle.
   assign s1.readdata      = (READ_LATENCY == 2) ? rdat_p2_q[0] : rdat_p1_q[0];
   assign s2.readdata      = (READ_LATENCY == 2) ? rdat_p2_q[1] : rdat_p1_q[1];
   assign s1.readdatavalid = en & ((READ_LATENCY == 2) ? vld_p2_q[0] : vld_p1_q[0]);
   assign s2.readdatavalid = en & ((READ_LATENCY == 2) ? vld_p2_q[1] : vld_p1_q[1]);
   assign s1.waitrequest   = wait_q | ~en;
   assign s2.waitrequest   = wait_q | ~en;

   assign clear_done    = done_q;
   assign collision_cnt = coll_q;
endmodule

// File: tb/tb_onchip_dpram_avl.sv
// Randomized bench for onchip_dpram_avl: a latency-1 and a latency-2 instance
// share stimulus and are compared against a word-array reference model.
module tb_onchip_dpram_avl;
   localparam int DW = 32;
   localparam int AW = 9;
   localparam int N  = 1 << AW;

   typedef struct packed {
      logic          v;
      logic [DW-1:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic reset, reset_req, clken;
   always #5 clk = ~clk;

   logic          cs [2], rd [2], wr [2];
   logic [AW-1:0] ad [2];
   logic [DW-1:0] wd [2];
   logic [3:0]    be [2];

   onchip_dpram_avl_if #(.DATA_W(DW), .ADDR_W(AW)) a1 ();
   onchip_dpram_avl_if #(.DATA_W(DW), .ADDR_W(AW)) a2 ();
   onchip_dpram_avl_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
   onchip_dpram_avl_if #(.DATA_W(DW), .ADDR_W(AW)) b2 ();

   assign a1.chipselect = cs[0]; assign a1.read = rd[0]; assign a1.write = wr[0];
   assign a1.address = ad[0];    assign a1.writedata = wd[0]; assign a1.byteenable = be[0];
   assign b1.chipselect = cs[0]; assign b1.read = rd[0]; assign b1.write = wr[0];
   assign b1.address = ad[0];    assign b1.writedata = wd[0]; assign b1.byteenable = be[0];
   assign a2.chipselect = cs[1]; assign a2.read = rd[1]; assign a2.write = wr[1];
   assign a2.address = ad[1];    assign a2.writedata = wd[1]; assign a2.byteenable = be[1];
   assign b2.chipselect = cs[1]; assign b2.read = rd[1]; assign b2.write = wr[1];
   assign b2.address = ad[1];    assign b2.writedata = wd[1]; assign b2.byteenable = be[1];

   logic [DW-1:0] o_rd [2][2];
   logic          o_rv [2][2];
   logic          o_wq [2][2];
   logic          cd [2];
   logic [15:0]   cc [2];

   assign o_rd[0][0] = a1.readdata; assign o_rv[0][0] = a1.readdatavalid; assign o_wq[0][0] = a1.waitrequest;
   assign o_rd[0][1] = a2.readdata; assign o_rv[0][1] = a2.readdatavalid; assign o_wq[0][1] = a2.waitrequest;
   assign o_rd[1][0] = b1.readdata; assign o_rv[1][0] = b1.readdatavalid; assign o_wq[1][0] = b1.waitrequest;
   assign o_rd[1][1] = b2.readdata; assign o_rv[1][1] = b2.readdatavalid; assign o_wq[1][1] = b2.waitrequest;

   onchip_dpram_avl #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_l1 (
      .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
      .s1(a1), .s2(a2), .clear_done(cd[0]), .collision_cnt(cc[0])
   );

   onchip_dpram_avl #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_l2 (
      .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
      .s1(b1), .s2(b2), .clear_done(cd[1]), .collision_cnt(cc[1])
   );

   // Reference model: word array, clear countdown, per-port history of reads per en-edge.
   logic [DW-1:0] mem_m [N];
   ent_t          hq0 [$];
   ent_t          hq1 [$];
   int            clear_left;
   int            coll_m;
   int            n_chk, n_pass;
   logic [DW-1:0] last_d [2][2];
   int            pulses [2][2];

   task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic ent_t hist(input int p, input int back);
      ent_t e;
      e = '0;
      if (p == 0) begin
         if (hq0.size() >= back) e = hq0[hq0.size() - back];
      end else begin
         if (hq1.size() >= back) e = hq1[hq1.size() - back];
      end
      return e;
   endfunction

   task automatic model_edge();
      ent_t e [2];
      logic w [2];
      e[0] = '0; e[1] = '0; w[0] = 1'b0; w[1] = 1'b0;
      if (clear_left > 0) begin
         mem_m[N - clear_left] = '0;
         clear_left--;
      end else begin
         for (int p = 0; p < 2; p++) begin
            w[p]    = cs[p] & wr[p];
            e[p].v  = cs[p] & rd[p] & ~wr[p];
            e[p].d  = e[p].v ? mem_m[ad[p]] : '0;
         end
         if (w[0] && w[1] && ad[0] == ad[1]) begin
            w[1] = 1'b0;
            if (coll_m < 65535) coll_m++;
         end
         for (int p = 1; p >= 0; p--)
            if (w[p])
               for (int b = 0; b < 4; b++)
                  if (be[p][b]) mem_m[ad[p]][8*b +: 8] = wd[p][8*b +: 8];
      end
      hq0.push_back(e[0]);
      hq1.push_back(e[1]);
      if (hq0.size() > 4) void'(hq0.pop_front());
      if (hq1.size() > 4) void'(hq1.pop_front());
   endtask

   task automatic cycle();
      logic en;
      ent_t e;
      @(negedge clk);
      en = clken & ~reset_req;
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            check_eq($sformatf("rst_done d%0d", d), DW'(cd[d]), '0);
            check_eq($sformatf("rst_coll d%0d", d), DW'(cc[d]), '0);
            for (int p = 0; p < 2; p++) begin
               check_eq($sformatf("rst_rdata d%0d p%0d", d, p), o_rd[d][p], '0);
               check_eq($sformatf("rst_valid d%0d p%0d", d, p), DW'(o_rv[d][p]), '0);
               check_eq($sformatf("rst_wait d%0d p%0d", d, p), DW'(o_wq[d][p]), 1);
            end
         end else begin
            check_eq($sformatf("clear_done d%0d", d), DW'(cd[d]), DW'(clear_left == 0));
            check_eq($sformatf("coll_cnt d%0d", d), DW'(cc[d]), DW'(coll_m));
            for (int p = 0; p < 2; p++) begin
               e = hist(p, d + 1);
               check_eq($sformatf("waitreq d%0d p%0d", d, p), DW'(o_wq[d][p]),
                        DW'((clear_left > 0) || !en));
               check_eq($sformatf("rdvalid d%0d p%0d", d, p), DW'(o_rv[d][p]), DW'(en & e.v));
               if (en && e.v) begin
                  check_eq($sformatf("rdata d%0d p%0d", d, p), o_rd[d][p], e.d);
                  last_d[d][p] = o_rd[d][p];
               end
               if (o_rv[d][p] === 1'b1) pulses[d][p]++;
            end
         end
      end
      if (reset) begin
         clear_left = N;
         coll_m     = 0;
         hq0.delete();
         hq1.delete();
      end else if (en) begin
         model_edge();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input logic c, input logic r, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] b);
      cs[p] = c; rd[p] = r; wr[p] = w; ad[p] = a; wd[p] = d; be[p] = b;
   endtask

   task automatic idle();
      for (int p = 0; p < 2; p++) drive(p, 1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   initial begin
      int cnt;
      n_chk = 0; n_pass = 0; coll_m = 0; clear_left = N;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) begin
            last_d[d][p] = '0;
            pulses[d][p] = 0;
         end
      reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
      idle();
      @(posedge clk); #1;
      cycle(); cycle();
      reset = 1'b0;

      // Interrupt the clear at address 5, then let it run to completion.
      repeat (5) cycle();
      reset = 1'b1; cycle(); reset = 1'b0;
      cnt = 0;
      while (cd[0] !== 1'b1 && cnt < N + 10) begin
         cycle();
         cnt++;
      end
      check_eq("clear_len", DW'(cnt), DW'(N));

      for (int i = 0; i < N; i++) begin
         drive(0, 1'b1, 1'b1, 1'b0, AW'(i), '0, '0);
         cycle();
      end
      idle(); repeat (3) cycle();

      // Byte-lane merge seen from the other port.
      drive(0, 1'b1, 1'b0, 1'b1, AW'(16), 32'h11223344, 4'hF); cycle();
      drive(0, 1'b1, 1'b0, 1'b1, AW'(16), 32'hDEADBEEF, 4'b0101); cycle();
      idle();
      drive(1, 1'b1, 1'b1, 1'b0, AW'(16), '0, '0); cycle();
      idle(); repeat (3) cycle();
      check_eq("be_merge l1", last_d[0][1], 32'h11AD33EF);
      check_eq("be_merge l2", last_d[1][1], 32'h11AD33EF);

      // Same-address double write.
      drive(0, 1'b1, 1'b0, 1'b1, AW'(12'h123), 32'hAAAA5555, 4'hF);
      drive(1, 1'b1, 1'b0, 1'b1, AW'(12'h123), 32'h12345678, 4'hF);
      cycle();
      idle();
      drive(0, 1'b1, 1'b1, 1'b0, AW'(12'h123), '0, '0); cycle();
      idle(); repeat (3) cycle();
      check_eq("collide_word", last_d[0][0], 32'hAAAA5555);
      check_eq("collide_cnt", DW'(cc[0]), 1);

      // Read-during-write on opposite ports returns old data; next read sees new.
      drive(0, 1'b1, 1'b1, 1'b0, AW'(12'h020), '0, '0);
      drive(1, 1'b1, 1'b0, 1'b1, AW'(12'h020), 32'h55, 4'hF);
      cycle();
      idle();
      drive(0, 1'b1, 1'b1, 1'b0, AW'(12'h020), '0, '0); cycle();
      idle(); repeat (3) cycle();
      check_eq("rdw_new", last_d[1][0], 32'h55);

      // Pipelined reads with a three-cycle clken stall in the middle.
      for (int i = 0; i < 8; i++) begin
         drive(1, 1'b1, 1'b0, 1'b1, AW'(i), 32'hC0DE0000 + 32'(i * 17), 4'hF);
         cycle();
      end
      idle();
      for (int d = 0; d < 2; d++) pulses[d][0] = 0;
      for (int i = 0; i < 8; i++) begin
         drive(0, 1'b1, 1'b1, 1'b0, AW'(i), '0, '0);
         if (i == 4) begin
            clken = 1'b0; repeat (3) cycle(); clken = 1'b1;
         end
         cycle();
      end
      idle(); repeat (4) cycle();
      check_eq("stall_pulses l1", DW'(pulses[0][0]), 8);
      check_eq("stall_pulses l2", DW'(pulses[1][0]), 8);

      // Randomized traffic, dense on a few addresses to provoke collisions.
      for (int k = 0; k < 3000; k++) begin
         clken     = ($urandom_range(0, 9) != 0);
         reset_req = ($urandom_range(0, 19) == 0);
         for (int p = 0; p < 2; p++)
            drive(p, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 1) ? AW'($urandom_range(0, 15)) : AW'($urandom),
                  $urandom, 4'($urandom));
         cycle();
      end
      clken = 1'b1; reset_req = 1'b0;
      idle(); repeat (3) cycle();

      // Counter saturation.
      drive(0, 1'b1, 1'b0, 1'b1, AW'(1), 32'h1, 4'hF);
      drive(1, 1'b1, 1'b0, 1'b1, AW'(1), 32'h2, 4'hF);
      repeat (70000) cycle();
      idle(); cycle();
      check_eq("coll_sat l1", DW'(cc[0]), 32'hFFFF);
      check_eq("coll_sat l2", DW'(cc[1]), 32'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/onchip_dpram_avl.md
# onchip_dpram_avl

Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slaves (s1 for the Nios II data master, s2 for correlator hardware), configurable width, depth and read latency. Adds readdatavalid/waitrequest handshakes, a hardware clear sequencer and write-collision arbitration. Drop-in successor for the 4096×32 single-port system RAM; s1 with READ_LATENCY=1 keeps its timing.

## Interface
- DATA_W, 32: word width; multiple of 8, 8..128
- ADDR_W, 12: word address width; depth = 2^ADDR_W
- READ_LATENCY, 1: 1 = unregistered q, 2 = output register; applies to both ports
- CLEAR_ON_RESET, 1: 1 = zero all words after reset; 0 = contents untouched
- clk  in  1  single clock for both ports
- reset  in  1  asynchronous, active-high
- reset_req  in  1  pauses both ports exactly as clken=0
- clken  in  1  global clock enable
- s1_chipselect, s1_read, s1_write  in  1 each  port 1 controls
- s1_address  in  ADDR_W  word address
- s1_byteenable  in  DATA_W/8  byte lanes
- s1_writedata  in  DATA_W
- s1_readdata  out  DATA_W
- s1_readdatavalid  out  1
- s1_waitrequest  out  1
- s2_*: same set and widths as s1_*
- clear_done  out  1  high once clear sequence finished (or immediately if CLEAR_ON_RESET=0)
- collision_cnt  out  16  saturating count of dropped s2 writes

## Operation
- Enable: en = clken & ~reset_req. en=0: no accepts, pipelines frozen, outputs hold, waitrequest=1 on both ports.
- FSM CLEAR → RUN. Leaves reset in CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR: counter 0..2^ADDR_W-1 writes all-zeros via port 1, one word per en cycle; both waitrequests=1. After writing the last address → RUN, clear_done=1. Reset mid-clear restarts at address 0.
- RUN: a port accepts when chipselect & (read|write) & en; waitrequest=0.
- Write: byte lanes with byteenable=1 updated; others preserved. byteenable=0 is a legal no-op write.
- read & write on one port same cycle: write wins, no readdatavalid.
- Collision: both ports write the same address in one accepted cycle → s1 committed, s2 dropped, collision_cnt+1 (saturates at 0xFFFF). Acceptance is unaffected for s2; no readdatavalid.
- Read on one port, write on the other, same address: reader returns OLD data.
- Read with chipselect=0 ignored; no readdatavalid.
- Address wraps naturally (width ADDR_W).

## Timing
- Reset values: readdata 0, readdatavalid 0, waitrequest 1 (CLEAR_ON_RESET=1) or 0, clear_done 0 (or 1), collision_cnt 0, clear counter 0.
- Read accepted at edge N: readdata/readdatavalid at cycle N+READ_LATENCY (en-cycles; frozen cycles don't count). readdatavalid high exactly one en-cycle per read; readdata holds last value otherwise.
- Back-to-back reads: one per cycle per port, fully pipelined; order preserved.
- Write visible to a read accepted on the next cycle (either port).
- Clear takes 2^ADDR_W en-cycles; clear_done rises the cycle after the last write.
- waitrequest is a registered function of state plus combinational en.

## Test plan
- Reset, CLEAR_ON_RESET=1, ADDR_W=4: waitrequest=1 for 16 cycles, clear_done at cycle 17; read all 16 words -> 0x00000000.
- s1 writes 0xDEADBEEF @0x010, byteenable 0b0101 over prior 0x11223344 -> s2 read @0x010 returns 0x11AD33EF one cycle later (READ_LATENCY=1), two with READ_LATENCY=2.
- Both ports write @0x123 same cycle (s1 0xAAAA5555, s2 0x12345678) -> word = 0xAAAA5555, collision_cnt=1; 70000 collisions -> 0xFFFF.
- s1 read @0x020 (old 0x0) while s2 writes 0x55 there -> s1_readdata=0x0; next-cycle read -> 0x55.
- Back-to-back reads @0..7 with clken dropped 3 cycles mid-stream -> eight readdatavalid pulses, data in order, none during the stall.
- Assert reset at clear address 5 -> counter restarts at 0, clear_done low until full 2^ADDR_W cycles elapse.
